// File: rtl/wr_fram_pkg.sv
// rtl/wr_fram_pkg.sv - shared constants, FSM encoding and helpers for the DDR write-side frame packer
package wr_fram_pkg;

    localparam int PIX_WIDTH_DEF  = 32;
    localparam int WORD_WIDTH_DEF = 256;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int BURST_LEN_DEF  = 16;

    function automatic int pix_per_word(input int word_width, input int pix_width);
        return word_width / pix_width;
    endfunction

    localparam int PIX_PER_WORD = pix_per_word(WORD_WIDTH_DEF, PIX_WIDTH_DEF);
    localparam int BLEN_WIDTH   = ADDR_WIDTH_DEF + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/wr_fram_sdpram.sv
// rtl/wr_fram_sdpram.sv - single-clock simple dual-port RAM with registered read port
module wr_fram_sdpram #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // The read register is cleared so the data output reads zero after reset or a new frame.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/wr_fram_pack.sv
// rtl/wr_fram_pack.sv - packs pixels into DDR words, buffers them and issues fixed-length write bursts
module wr_fram_pack
    import wr_fram_pkg::*;
#(
    parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [PIX_WIDTH-1:0]  pix_data,
    input  logic                  pix_valid,
    input  logic                  line_end,
    input  logic                  frame_flush,
    output logic                  ddr_wr_req,
    input  logic                  ddr_wr_ack,
    output logic [ADDR_WIDTH:0]   ddr_burst_len,
    input  logic                  ddr_rd_en,
    output logic [WORD_WIDTH-1:0] ddr_wr_data,
    output logic                  ddr_wr_valid,
    output logic                  burst_done,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  overflow
);

    localparam int PPW   = pix_per_word(WORD_WIDTH, PIX_WIDTH);
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(PPW - 1);
    localparam logic [ADDR_WIDTH:0] FULL     = (ADDR_WIDTH + 1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] BLEN     = (ADDR_WIDTH + 1)'(BURST_LEN);

    logic [WORD_WIDTH-1:0] word_d, word_q, word_nxt;
    logic [IDX_W-1:0]      idx_d, idx_q;
    logic [ADDR_WIDTH-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
    logic [ADDR_WIDTH:0]   fill_d, fill_q, len_d, len_q, cnt_d, cnt_q;
    logic [1:0]            state_d, state_q;
    logic                  ovf_d, ovf_q, flush_d, flush_q, valid_d, valid_q;
    logic                  complete, push, pop;

    // Packer: slots beyond the current index are already zero, so a line_end word is zero-padded.
    always_comb begin
        word_nxt = word_q;
        word_nxt[idx_q*PIX_WIDTH +: PIX_WIDTH] = pix_data;
        complete = pix_valid && (idx_q == LAST_IDX || line_end);
        word_d   = word_q;
        idx_d    = idx_q;
        if (complete) begin
            word_d = '0;
            idx_d  = '0;
        end else if (pix_valid) begin
            word_d = word_nxt;
            idx_d  = idx_q + 1'b1;
        end
    end

    always_comb begin
        push    = complete && (fill_q != FULL);
        pop     = (state_q == ST_BURST) && ddr_rd_en && (fill_q != '0);
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        fill_d  = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end
        ovf_d   = ovf_q || (complete && !push);
        valid_d = pop;
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_q >= BLEN) begin
                    state_d = ST_REQ;
                    len_d   = BLEN;
                    flush_d = 1'b0;
                end else if (flush_q && fill_q != '0) begin
                    state_d = ST_REQ;
                    len_d   = fill_q;
                    flush_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (ddr_wr_ack) begin
                    state_d = ST_BURST;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (pop) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh flush pulse is never lost to a same-cycle REQ entry.
        if (frame_flush) begin
            flush_d = (fill_q != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            word_q  <= '0;
            idx_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
            flush_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            flush_q <= flush_d;
            valid_q <= valid_d;
        end
    end

    wr_fram_sdpram #(
        .DATA_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .clr    (rst || frame_start),
        .wr_en  (push),
        .wr_addr(wptr_q),
        .wr_data(word_nxt),
        .rd_en  (pop),
        .rd_addr(rptr_q),
        .rd_data(ddr_wr_data)
    );

    assign ddr_wr_req    = (state_q == ST_REQ);
    assign burst_done    = (state_q == ST_DONE);
    assign ddr_burst_len = len_q;
    assign fill_level    = fill_q;
    assign overflow      = ovf_q;
    assign ddr_wr_valid  = valid_q;

endmodule

// File: tb/tb_wr_fram_pack.sv
// tb/tb_wr_fram_pack.sv - scoreboard bench for wr_fram_pack
module tb_wr_fram_pack;
    import wr_fram_pkg::*;

    logic         clk = 1'b0;
    logic         rst, frame_start, pix_valid, line_end, frame_flush;
    logic [31:0]  pix_data;
    logic         ddr_wr_req, ddr_wr_ack, ddr_rd_en, ddr_wr_valid, burst_done, overflow;
    logic [6:0]   ddr_burst_len, fill_level;
    logic [255:0] ddr_wr_data;

    int           n_vec = 0;
    int           n_miss = 0;
    int           n_done = 0;
    logic [255:0] sb[$];
    logic [255:0] mw = '0;
    int           mk = 0;

    always #5 clk = ~clk;

    wr_fram_pack dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .line_end     (line_end),
        .frame_flush  (frame_flush),
        .ddr_wr_req   (ddr_wr_req),
        .ddr_wr_ack   (ddr_wr_ack),
        .ddr_burst_len(ddr_burst_len),
        .ddr_rd_en    (ddr_rd_en),
        .ddr_wr_data  (ddr_wr_data),
        .ddr_wr_valid (ddr_wr_valid),
        .burst_done   (burst_done),
        .fill_level   (fill_level),
        .overflow     (overflow)
    );

    task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (burst_done) n_done++;
        if (ddr_wr_valid) begin
            if (sb.size() == 0) check_vec("spurious_valid", ddr_wr_valid, 0);
            else check_vec("wr_data", ddr_wr_data, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        mw = '0;
        mk = 0;
    endtask

    task automatic send_pix(input logic [31:0] d, input logic le);
        pix_data  = d;
        pix_valid = 1'b1;
        line_end  = le;
        mw[32*mk +: 32] = d;
        if (mk == PIX_PER_WORD - 1 || le) begin
            if (sb.size() < 64) sb.push_back(mw);
            mw = '0;
            mk = 0;
        end else begin
            mk++;
        end
        tick();
        pix_valid = 1'b0;
        line_end  = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 300; i++) begin
            if (ddr_wr_req) break;
            tick();
        end
        check_vec("req_seen", ddr_wr_req, 1);
    endtask

    task automatic do_burst(input int len);
        wait_req();
        check_vec("burst_len", ddr_burst_len, len);
        ddr_wr_ack = 1'b1;
        tick();
        ddr_wr_ack = 1'b0;
        check_vec("req_drop", ddr_wr_req, 0);
        ddr_rd_en = 1'b1;
        repeat (len) tick();
        ddr_rd_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1; frame_start = 0; pix_valid = 0; line_end = 0; frame_flush = 0;
        pix_data = '0; ddr_wr_ack = 0; ddr_rd_en = 0;
        repeat (3) tick();
        check_vec("reset_ctl", {ddr_wr_req, ddr_wr_valid, burst_done, overflow, fill_level, ddr_burst_len}, 0);
        check_vec("reset_data", ddr_wr_data, 0);
        rst = 1'b0;
        tick();

        // 16 full words, one full burst
        for (int i = 0; i < 128; i++) send_pix(32'(i), 1'b0);
        wait_req();
        check_vec("t1_fill", fill_level, 16);
        do_burst(16);
        check_vec("t1_done", n_done, 1);
        check_vec("t1_fill_end", fill_level, 0);

        // flush with empty buffer issues nothing
        frame_flush = 1'b1; tick(); frame_flush = 1'b0;
        repeat (5) tick();
        check_vec("flush_empty_req", ddr_wr_req, 0);

        // short line, then flush as a one-word burst
        send_pix(32'hAAAA_0001, 1'b0);
        send_pix(32'hBBBB_0002, 1'b0);
        send_pix(32'hCCCC_0003, 1'b1);
        repeat (4) tick();
        check_vec("t2_fill", fill_level, 1);
        check_vec("t2_noreq", ddr_wr_req, 0);
        frame_flush = 1'b1; tick(); frame_flush = 1'b0;
        do_burst(1);
        check_vec("t2_done", n_done, 2);
        check_vec("t2_fill_end", fill_level, 0);

        // overflow: 65 words with no grant
        for (int i = 0; i < 65 * 8; i++) send_pix(32'h1000_0000 + 32'(i), 1'b0);
        tick();
        check_vec("t3_fill_sat", fill_level, 64);
        check_vec("t3_ovf", overflow, 1);
        do_burst(16);
        check_vec("t3_fill_after", fill_level, 48);
        check_vec("t3_ovf_sticky", overflow, 1);
        pulse_frame_start();
        check_vec("t3_clr", {overflow, fill_level, ddr_wr_req}, 0);

        // concurrent push/pop across pointer wrap
        d0 = n_done;
        fork
            for (int i = 0; i < 80 * 8; i++) send_pix(32'h4000_0000 + 32'(i), 1'b0);
            for (int b = 0; b < 5; b++) do_burst(16);
        join
        repeat (4) tick();
        check_vec("t4_done", n_done, d0 + 5);
        check_vec("t4_fill_end", fill_level, 0);
        check_vec("t4_sb_empty", sb.size(), 0);

        // abort a burst after 5 pops
        for (int i = 0; i < 128; i++) send_pix(32'h5000_0000 + 32'(i), 1'b0);
        wait_req();
        d0 = n_done;
        ddr_wr_ack = 1'b1; tick(); ddr_wr_ack = 1'b0;
        ddr_rd_en = 1'b1;
        repeat (5) tick();
        pulse_frame_start();
        check_vec("t5_state", {ddr_wr_req, fill_level}, 0);
        repeat (10) tick();
        ddr_rd_en = 1'b0;
        check_vec("t5_nodone", n_done, d0);
        check_vec("t5_quiet", {ddr_wr_valid, ddr_wr_req, fill_level}, 0);

        // reset mid-stream
        for (int i = 0; i < 20; i++) send_pix(32'h6000_0000 + 32'(i), 1'b0);
        rst = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 32'hDEAD_BEEF;
        tick();
        check_vec("t6_rst_ctl", {ddr_wr_req, ddr_wr_valid, burst_done, overflow, fill_level, ddr_burst_len}, 0);
        tick();
        tick();
        pix_valid = 1'b0;
        rst = 1'b0;
        model_clear();
        check_vec("t6_rst_data", ddr_wr_data, 0);
        for (int i = 0; i < 8; i++) send_pix(32'h7000_0000 + 32'(i), 1'b0);
        tick();
        check_vec("t6_fill", fill_level, 1);
        frame_flush = 1'b1; tick(); frame_flush = 1'b0;
        do_burst(1);
        check_vec("t6_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
